// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control decoder. Decodes the opcode in ID and carries the
// control bundle through EX/MEM/WB, with RAW hazard stalls, branch squash and
// HALT retirement tracking.
// Optional feature macro: CTRL_PIPE_FWD_EN (adds forwarding select outputs and
// restricts stalls to load-use).
//
// Halt tracker states:
//   state  | meaning
//   RUN    | normal operation, no HALT has retired
//   HALTED | a HALT has left WB; ID stays blocked until reset
module ctrl_pipe #(
    parameter int OP_W    = 5,
    parameter int ALUOP_W = 5,
    parameter int RA_W    = 3,
    parameter int CTRL_W  = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr_i,
    input  logic              instr_vld_i,
    input  logic              mem_busy_i,
    input  logic              br_taken_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [RA_W-1:0]   ex_dst_o,
    output logic [CTRL_W-1:0] mem_ctrl_o,
    output logic [RA_W-1:0]   mem_dst_o,
    output logic [CTRL_W-1:0] wb_ctrl_o,
    output logic [RA_W-1:0]   wb_dst_o,
`ifdef CTRL_PIPE_FWD_EN
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
`endif
    output logic              halted_o
);

    // Immediate-select encodings carried in the bundle
    localparam logic [2:0] IMM_5S  = 3'd0;
    localparam logic [2:0] IMM_5Z  = 3'd1;
    localparam logic [2:0] IMM_8S  = 3'd2;
    localparam logic [2:0] IMM_8Z  = 3'd3;
    localparam logic [2:0] IMM_11S = 3'd4;

    localparam logic [ALUOP_W-1:0] ALU_ADDI = 5'b01000;
    localparam logic [RA_W-1:0]    LINK_REG = 3'd7;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               val2reg;
        logic               alu_sel;
        logic               jump;
        logic               branch;
        logic               pc2reg;
        logic               halt;
        logic [2:0]         imm_sel;
        logic [ALUOP_W-1:0] alu_cntrl;
    } ctrl_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

    logic [OP_W-1:0] opcode;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            rs_used;
    logic            rt_used;
    ctrl_t           id_ctrl;
    logic [RA_W-1:0] id_dst;

    ctrl_t           ex_ctrl;
    ctrl_t           mem_ctrl;
    ctrl_t           wb_ctrl;
    logic [RA_W-1:0] ex_dst;
    logic [RA_W-1:0] mem_dst;
    logic [RA_W-1:0] wb_dst;

    halt_state_t     state;
    halt_state_t     state_nxt;

    logic            hazard;
    logic            halt_block;
    logic            ex_bubble;
    logic            stall_c;

    // Fields not consumed by control decode (function bits, immediates)
    logic            unused_instr;

    assign opcode       = instr_i[15 -: OP_W];
    assign rs           = instr_i[10:8];
    assign rt           = instr_i[7:5];
    assign unused_instr = &{1'b0, instr_i};

    // ID decode: opcode class to control bundle, destination and source usage
    always_comb begin
        id_ctrl = '0;
        id_dst  = '0;
        rs_used = 1'b0;
        rt_used = 1'b0;
        if (instr_vld_i) begin
            casez (opcode)
                5'b010??, 5'b101??: begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = opcode[1] ? IMM_5Z : IMM_5S;
                    id_ctrl.alu_cntrl = opcode;
                    id_dst            = instr_i[7:5];
                    rs_used           = 1'b1;
                end
                5'b10000: begin
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = IMM_5S;
                    id_ctrl.alu_cntrl = ALU_ADDI;
                    rs_used           = 1'b1;
                    rt_used           = 1'b1;
                end
                5'b10001: begin
                    id_ctrl.mem_read  = 1'b1;
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.val2reg   = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = IMM_5S;
                    id_ctrl.alu_cntrl = ALU_ADDI;
                    id_dst            = instr_i[7:5];
                    rs_used           = 1'b1;
                end
                5'b10011: begin
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = IMM_5S;
                    id_ctrl.alu_cntrl = ALU_ADDI;
                    id_dst            = instr_i[10:8];
                    rs_used           = 1'b1;
                    rt_used           = 1'b1;
                end
                5'b11001, 5'b1101?, 5'b111??: begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_cntrl = opcode;
                    id_dst            = instr_i[4:2];
                    rs_used           = 1'b1;
                    rt_used           = 1'b1;
                end
                5'b11000: begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = IMM_8S;
                    id_ctrl.alu_cntrl = opcode;
                    id_dst            = instr_i[10:8];
                end
                5'b10010: begin
                    // SLBI shifts the old Rs value, so it reads as well as writes
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = IMM_8Z;
                    id_ctrl.alu_cntrl = opcode;
                    id_dst            = instr_i[10:8];
                    rs_used           = 1'b1;
                end
                5'b011??: begin
                    id_ctrl.branch    = 1'b1;
                    id_ctrl.imm_sel   = IMM_8S;
                    id_ctrl.alu_cntrl = opcode;
                    rs_used           = 1'b1;
                end
                5'b00100, 5'b00110: begin
                    id_ctrl.jump    = 1'b1;
                    id_ctrl.imm_sel = IMM_11S;
                    if (opcode[1]) begin
                        id_ctrl.pc2reg    = 1'b1;
                        id_ctrl.reg_write = 1'b1;
                        id_dst            = LINK_REG;
                    end
                end
                5'b00101, 5'b00111: begin
                    id_ctrl.jump      = 1'b1;
                    id_ctrl.alu_sel   = 1'b1;
                    id_ctrl.imm_sel   = IMM_8S;
                    id_ctrl.alu_cntrl = ALU_ADDI;
                    rs_used           = 1'b1;
                    if (opcode[1]) begin
                        id_ctrl.pc2reg    = 1'b1;
                        id_ctrl.reg_write = 1'b1;
                        id_dst            = LINK_REG;
                    end
                end
                5'b00000: begin
                    id_ctrl.halt = 1'b1;
                end
                default: begin
                    id_ctrl = '0;
                end
            endcase
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    // Load-use only: ALU results are forwarded, load data is not ready in MEM
    always_comb begin
        hazard = ex_ctrl.mem_read && ex_ctrl.reg_write &&
                 ((rs_used && (ex_dst == rs)) || (rt_used && (ex_dst == rt)));
    end
`else
    // Full RAW interlock against every in-flight writer ahead of WB
    always_comb begin
        hazard = (rs_used && ((ex_ctrl.reg_write  && (ex_dst  == rs)) ||
                              (mem_ctrl.reg_write && (mem_dst == rs)))) ||
                 (rt_used && ((ex_ctrl.reg_write  && (ex_dst  == rt)) ||
                              (mem_ctrl.reg_write && (mem_dst == rt))));
    end
`endif

    // A HALT anywhere past ID, or an already retired one, blocks new work
    always_comb begin
        halt_block = ex_ctrl.halt || mem_ctrl.halt || wb_ctrl.halt || (state == HALTED);
        ex_bubble  = br_taken_i || hazard || halt_block;
    end

    // Stall/flush priority: memory freeze, then branch squash, then interlocks
    always_comb begin
        stall_c = 1'b0;
        if (mem_busy_i) begin
            stall_c = 1'b1;
        end else if (br_taken_i) begin
            stall_c = 1'b0;
        end else begin
            stall_c = hazard || halt_block || id_ctrl.halt;
        end
    end

    // Outputs forced low while reset is held so fetch sees a quiet pipe
    assign stall_o = rst_n & stall_c;
    assign flush_o = rst_n & br_taken_i & ~mem_busy_i;

    // Stage registers: freeze on mem_busy_i, otherwise advance with EX bubble insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= '0;
            mem_ctrl <= '0;
            wb_ctrl  <= '0;
            ex_dst   <= '0;
            mem_dst  <= '0;
            wb_dst   <= '0;
        end else if (!mem_busy_i) begin
            wb_ctrl  <= mem_ctrl;
            wb_dst   <= mem_dst;
            mem_ctrl <= ex_ctrl;
            mem_dst  <= ex_dst;
            if (ex_bubble) begin
                ex_ctrl <= '0;
                ex_dst  <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_dst  <= id_dst;
            end
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic            ex_rs_used;
    logic            ex_rt_used;

    // Source registers travel with the EX bundle to drive the forwarding muxes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rs_used <= 1'b0;
            ex_rt_used <= 1'b0;
        end else if (!mem_busy_i) begin
            if (ex_bubble) begin
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_rs_used <= 1'b0;
                ex_rt_used <= 1'b0;
            end else begin
                ex_rs      <= rs;
                ex_rt      <= rt;
                ex_rs_used <= rs_used;
                ex_rt_used <= rt_used;
            end
        end
    end

    // Forward select: 01 from MEM (younger result wins), 10 from WB, 00 register file
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (ex_rs_used && mem_ctrl.reg_write && (mem_dst == ex_rs)) begin
            fwd_a_o = 2'b01;
        end else if (ex_rs_used && wb_ctrl.reg_write && (wb_dst == ex_rs)) begin
            fwd_a_o = 2'b10;
        end
        if (ex_rt_used && mem_ctrl.reg_write && (mem_dst == ex_rt)) begin
            fwd_b_o = 2'b01;
        end else if (ex_rt_used && wb_ctrl.reg_write && (wb_dst == ex_rt)) begin
            fwd_b_o = 2'b10;
        end
    end
`endif

    // Halt tracker state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt tracker next state: a HALT sitting in WB retires
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (wb_ctrl.halt) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // halted_o rises while HALT is in WB and then holds from the tracker
    assign halted_o   = (state == HALTED) || wb_ctrl.halt;

    assign ex_ctrl_o  = ex_ctrl;
    assign mem_ctrl_o = mem_ctrl;
    assign wb_ctrl_o  = wb_ctrl;
    assign ex_dst_o   = ex_dst;
    assign mem_dst_o  = mem_dst;
    assign wb_dst_o   = wb_dst;

endmodule
